// File: rtl/alt_arb_pkg.sv
// Shared constants and context-state type for the alternation-detect stream arbiter.
package alt_arb_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned RUN_W  = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAVE0 = 2'd1,
    HAVE1 = 2'd2
  } ctx_state_e;

  function automatic ctx_state_e have_state(input logic b);
    return b ? HAVE1 : HAVE0;
  endfunction

endpackage

// File: rtl/alt_detect_core.sv
// Combinational context update for the granted channel: next state, next run length,
// and whether the updated run reaches the detection threshold.
module alt_detect_core
  import alt_arb_pkg::*;
#(
  parameter int unsigned RUN_THRESH = 4
) (
  input  logic [1:0]       i_state,
  input  logic [RUN_W-1:0] i_run,
  input  logic             i_bit,
  output logic [1:0]       o_state,
  output logic [RUN_W-1:0] o_run,
  output logic             o_hit
);

  logic w_last_bit;

  assign w_last_bit = (i_state == HAVE1);

  always_comb begin
    o_state = have_state(i_bit);
    o_run   = RUN_W'(1);
    if (i_state == EMPTY) begin
      o_run = RUN_W'(1);
    end else if (w_last_bit != i_bit) begin
      // Saturate rather than wrap so long alternations keep flagging.
      o_run = (i_run == RUN_MAX) ? RUN_MAX : i_run + RUN_W'(1);
    end
    o_hit = 32'(o_run) >= RUN_THRESH;
  end

endmodule

// File: rtl/alt_stream_arbiter.sv
// Round-robin arbiter sharing one alternation detector across four serial channels.
// Optional per-channel detection counters enabled by ALT_STREAM_ARB_STATS_EN.
module alt_stream_arbiter
  import alt_arb_pkg::*;
#(
  parameter int unsigned RUN_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         bit_in,
  output logic [NUM_CH-1:0]         gnt,
  output logic                      y,
  output logic [CH_W-1:0]           y_ch,
  output logic [NUM_CH*CNT_W-1:0]   det_cnt
);

  logic [CH_W-1:0]   r_ptr;
  logic [1:0]        r_state [NUM_CH];
  logic [RUN_W-1:0]  r_run   [NUM_CH];
  logic              r_y;
  logic [CH_W-1:0]   r_y_ch;

  logic [NUM_CH-1:0] w_gnt;
  logic              w_valid;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_cand;
  logic [1:0]        w_next_state;
  logic [RUN_W-1:0]  w_next_run;
  logic              w_hit;

  // First requester at or after the pointer, wrapping; nothing granted during reset.
  always_comb begin
    w_gnt   = '0;
    w_valid = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_cand = r_ptr + CH_W'(k);
        if (!w_valid && req[w_cand]) begin
          w_valid       = 1'b1;
          w_idx         = w_cand;
          w_gnt[w_cand] = 1'b1;
        end
      end
    end
  end

  assign gnt = w_gnt;

  alt_detect_core #(
    .RUN_THRESH (RUN_THRESH)
  ) u_core (
    .i_state (r_state[w_idx]),
    .i_run   (r_run[w_idx]),
    .i_bit   (bit_in[w_idx]),
    .o_state (w_next_state),
    .o_run   (w_next_run),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_y    <= 1'b0;
      r_y_ch <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        r_state[k] <= EMPTY;
        r_run[k]   <= '0;
      end
    end else begin
      r_y <= w_valid && w_hit;
      if (w_valid) begin
        r_state[w_idx] <= w_next_state;
        r_run[w_idx]   <= w_next_run;
        r_ptr          <= w_idx + CH_W'(1);
        if (w_hit) begin
          r_y_ch <= w_idx;
        end
      end
    end
  end

  assign y    = r_y;
  assign y_ch = r_y_ch;

`ifdef ALT_STREAM_ARB_STATS_EN
  logic [CNT_W-1:0] r_det_cnt [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] w_det_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        r_det_cnt[k] <= '0;
      end
    end else if (w_valid && w_hit && (r_det_cnt[w_idx] != '1)) begin
      r_det_cnt[w_idx] <= r_det_cnt[w_idx] + CNT_W'(1);
    end
  end

  always_comb begin
    w_det_cnt = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_det_cnt[k*CNT_W +: CNT_W] = r_det_cnt[k];
    end
  end

  assign det_cnt = w_det_cnt;
`else
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_alt_stream_arbiter.sv
// Self-checking bench for alt_stream_arbiter against a queue-free behavioural model
// of round-robin grants and per-channel alternation run tracking.
module tb_alt_stream_arbiter;

  localparam int unsigned RUN_THRESH = 4;
`ifdef ALT_STREAM_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  bit_in;
  logic [3:0]  gnt;
  logic        y;
  logic [1:0]  y_ch;
  logic [31:0] det_cnt;

  int total = 0;
  int bad   = 0;

  // Model: pointer, last bit per channel (-1 = none yet), run length, counters.
  int   m_ptr;
  int   m_last [4];
  int   m_run  [4];
  logic m_y;
  int   m_ych;
  int   m_cnt  [4];

  alt_stream_arbiter #(
    .RUN_THRESH (RUN_THRESH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bit_in  (bit_in),
    .gnt     (gnt),
    .y       (y),
    .y_ch    (y_ch),
    .det_cnt (det_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int exp_idx();
    if (rst) return -1;
    for (int k = 0; k < 4; k++) begin
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    int c;
    c = exp_idx();
    if (c < 0) return 4'b0000;
    return 4'(1 << c);
  endfunction

  function automatic logic [31:0] exp_det();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(m_cnt[k]);
    return v;
  endfunction

  task automatic model_step();
    int c;
    int b;
    if (rst) begin
      m_ptr = 0;
      m_y   = 1'b0;
      m_ych = 0;
      for (int k = 0; k < 4; k++) begin
        m_last[k] = -1;
        m_run[k]  = 0;
        m_cnt[k]  = 0;
      end
    end else begin
      c   = exp_idx();
      m_y = 1'b0;
      if (c >= 0) begin
        b = int'(bit_in[c]);
        if (m_last[c] < 0 || b == m_last[c]) m_run[c] = 1;
        else m_run[c] = (m_run[c] + 1 > 15) ? 15 : m_run[c] + 1;
        m_last[c] = b;
        m_ptr = (c + 1) % 4;
        if (m_run[c] >= int'(RUN_THRESH)) begin
          m_y   = 1'b1;
          m_ych = c;
          if (STATS != 0 && m_cnt[c] < 255) m_cnt[c]++;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] b);
    rst    = r;
    req    = q;
    bit_in = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b1, 4'b0000, 4'b0000);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, 4'($urandom));
      total++;
      if (gnt !== 4'b0000) begin
        bad++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", i, gnt);
      end
      tick();
      total++;
      if (y !== 1'b0 || y_ch !== 2'd0 || det_cnt !== 32'd0) begin
        bad++; $display("FAIL reset_out cyc%0d: got y=%b y_ch=%0d det=%h want 0 0 0",
                        i, y, y_ch, det_cnt);
      end
    end
    drive(1'b0, 4'b1111, 4'b0000);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL reset_release_gnt: got %b want 0001", gnt);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_list [8];
    exp_list = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1111, 4'($urandom));
      total++;
      if (gnt !== exp_list[i] || gnt !== exp_gnt()) begin
        bad++; $display("FAIL rr_gnt cyc%0d: got %b want %b", i, gnt, exp_list[i]);
      end
      tick();
      total++;
      if (y !== m_y) begin
        bad++; $display("FAIL rr_y cyc%0d: got %b want %b", i, y, m_y);
      end
    end
  endtask

  task automatic test_alt_ch2();
    logic bits  [6];
    logic exp_y [6];
    bits  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_y = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      // Other channels' data bits are noise and must be ignored.
      drive(1'b0, 4'b0100, {1'($urandom), bits[i], 2'($urandom)});
      total++;
      if (gnt !== 4'b0100) begin
        bad++; $display("FAIL ch2_gnt bit%0d: got %b want 0100", i, gnt);
      end
      tick();
      total++;
      if (y !== exp_y[i] || (exp_y[i] && y_ch !== 2'd2)) begin
        bad++; $display("FAIL ch2_y bit%0d: got y=%b y_ch=%0d want y=%b y_ch=2",
                        i, y, y_ch, exp_y[i]);
      end
    end
    total++;
    if (y_ch !== 2'd2) begin
      bad++; $display("FAIL ch2_ych_hold: got %0d want 2", y_ch);
    end
  endtask

  task automatic test_interleave();
    logic seq0 [4];
    int   ycount;
    seq0   = '{1'b1, 1'b0, 1'b1, 1'b0};
    ycount = 0;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b0011, {2'b00, 1'b1, seq0[i/2]});
      total++;
      if (gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b0010)) begin
        bad++; $display("FAIL intl_gnt cyc%0d: got %b", i, gnt);
      end
      tick();
      if (y === 1'b1) begin
        ycount++;
        total++;
        if (y_ch !== 2'd0) begin
          bad++; $display("FAIL intl_ych cyc%0d: got %0d want 0", i, y_ch);
        end
      end
    end
    total++;
    if (ycount != 1) begin
      bad++; $display("FAIL intl_ycount: got %0d want 1", ycount);
    end
  endtask

  task automatic test_reset_mid_run();
    logic pre   [3];
    logic post  [4];
    logic exp_y [4];
    pre   = '{1'b0, 1'b1, 1'b0};
    post  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_y = '{1'b0, 1'b0, 1'b0, 1'b1};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1000, {pre[i], 3'b000});
      tick();
    end
    drive(1'b1, 4'b1000, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1000, {post[i], 3'($urandom)});
      tick();
      total++;
      if (y !== exp_y[i] || (exp_y[i] && y_ch !== 2'd3)) begin
        bad++; $display("FAIL midrst_y bit%0d: got y=%b y_ch=%0d want y=%b",
                        i, y, y_ch, exp_y[i]);
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 40) == 0, 4'($urandom), 4'($urandom));
      total++;
      if (gnt !== exp_gnt()) begin
        bad++; $display("FAIL rand_gnt cyc%0d: got %b want %b", i, gnt, exp_gnt());
      end
      tick();
      total++;
      if (y !== m_y || y_ch !== 2'(m_ych) || det_cnt !== exp_det()) begin
        bad++; $display("FAIL rand_out cyc%0d: got y=%b ch=%0d det=%h want y=%b ch=%0d det=%h",
                        i, y, y_ch, det_cnt, m_y, m_ych, exp_det());
      end
    end
  endtask

  task automatic test_stats();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b0010, {2'b00, 1'(i % 2), 1'b0});
      tick();
    end
    total++;
    if (det_cnt[15:8] !== 8'(3 * STATS) || det_cnt !== exp_det()) begin
      bad++; $display("FAIL stats_three: got %h want ch1=%0d", det_cnt, 3 * STATS);
    end
    for (int i = 6; i < 306; i++) begin
      drive(1'b0, 4'b0010, {2'b00, 1'(i % 2), 1'b0});
      tick();
      total++;
      if (y !== m_y || det_cnt !== exp_det()) begin
        bad++; $display("FAIL stats_run bit%0d: got y=%b det=%h want y=%b det=%h",
                        i, y, det_cnt, m_y, exp_det());
      end
    end
    total++;
    if (det_cnt[15:8] !== 8'(255 * STATS) || y !== 1'b1) begin
      bad++; $display("FAIL stats_sat: got ch1=%0d y=%b want ch1=%0d y=1",
                      det_cnt[15:8], y, 255 * STATS);
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    bit_in = 4'b0000;
    m_ptr  = 0;
    m_y    = 1'b0;
    m_ych  = 0;
    for (int k = 0; k < 4; k++) begin
      m_last[k] = -1;
      m_run[k]  = 0;
      m_cnt[k]  = 0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_alt_ch2();
    test_interleave();
    test_reset_mid_run();
    test_random();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alt_stream_arbiter.md
ALT_STREAM_ARBITER -- requirements
Module: alt_stream_arbiter

Interface
REQ-001 SHALL have parameter RUN_THRESH, default 4, the alternation run length (2..15) at which a detection is flagged.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  4  per-channel request; bit i means channel i presents a serial bit this cycle.
REQ-005 SHALL have port bit_in  input  4  per-channel serial data bit, valid when the matching req bit is high.
REQ-006 SHALL have port gnt  output  4  one-hot grant; the granted channel's bit is consumed this cycle.
REQ-007 SHALL have port y  output  1  detection pulse, registered.
REQ-008 SHALL have port y_ch  output  2  channel index qualifying y.
REQ-009 SHALL have port det_cnt  output  32  per-channel detection counters, channel i in bits [8i+7:8i].

Function
REQ-010 SHALL share one alternation-detect engine among 4 channels by round-robin arbitration.
REQ-011 SHALL drive gnt combinationally: first requesting channel at or after pointer ptr, wrapping 3->0; gnt=0 when req=0.
REQ-012 SHALL set ptr to (granted index+1) mod 4 on each grant; ptr SHALL hold when no grant.
REQ-013 SHALL keep per-channel context: state EMPTY/HAVE0/HAVE1 and a 4-bit run count.
REQ-014 SHALL update only the granted channel's context: EMPTY -> HAVE<bit>, run=1; bit != last bit -> HAVE<bit>, run=min(run+1,15); bit == last bit -> run=1.
REQ-015 SHALL assert y for exactly one cycle, the cycle after consumption, when the updated run >= RUN_THRESH; y_ch SHALL equal the consumed channel.
REQ-016 SHALL hold y=0 and y_ch at its previous value in cycles with no consumption or no qualifying run.
REQ-017 SHALL saturate run at 15 with no wrap; y continues to pulse for each further alternating bit.
REQ-018 SHALL ignore bit_in of non-granted channels; an ungranted request is not buffered and the requester holds req.

Reset
REQ-019 SHALL force gnt=0 while rst is high, regardless of req.
REQ-020 SHALL on a clock edge with rst high set ptr=0, all contexts EMPTY with run=0, y=0, y_ch=0, det_cnt=0.
REQ-021 SHALL discard any in-progress run on reset mid-operation; the first bit after reset starts run=1.

Configuration
REQ-022 SHALL, with macro ALT_STREAM_ARB_STATS_EN defined, increment channel i's 8-bit det_cnt field on each y pulse for channel i, saturating at 255.
REQ-023 SHALL, without ALT_STREAM_ARB_STATS_EN, keep the det_cnt port and drive it constant 0 with no counter flops.

Structure
REQ-024 SHALL place NUM_CH=4, RUN_W=4, CNT_W=8 and the context state enum (EMPTY, HAVE0, HAVE1) in shared package alt_arb_pkg.
REQ-025 SHALL implement per-channel context update (REQ-014) as sub-module alt_detect_core, instantiated once and fed by the granted channel's muxed context.

Verification
REQ-026 SHALL cover: rst high 2 cycles with req=4'b1111 -> gnt=0, y=0; first cycle after release gnt=4'b0001.
REQ-027 SHALL cover: req=4'b1111 held 8 cycles -> gnt 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-028 SHALL cover: only ch2 requesting, bits 0,1,0,1,0,0 with RUN_THRESH=4 -> y=1,y_ch=2 after 4th and 5th bits; no y after 6th (run=1).
REQ-029 SHALL cover: ch0 bits 1,0,1,0 and ch1 bits 1,1,1,1 interleaved -> single y with y_ch=0; ch1 never flags.
REQ-030 SHALL cover: ch3 at run=3, one-cycle rst, then ch3 bit opposite to last -> run=1, no y.
REQ-031 SHALL cover with ALT_STREAM_ARB_STATS_EN: 3 detections on ch1 -> det_cnt[15:8]=3; 300 detections -> 255; without macro det_cnt=0 throughout.
